// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the cpu_ctrl controller slice
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG,
    S_WR_IMM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_MOV_IMM,
    C_MOV_REG,
    C_ADD,
    C_CMP,
    C_AND,
    C_MVN,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction handshake, datapath strobes and status between controller and datapath
interface cpu_ctrl_if;

  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_z;
  logic        alu_n;
  logic        alu_v;
  logic [1:0]  alu_op;
  logic [1:0]  shift;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] sximm8;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        asel;
  logic        Z;
  logic        N;
  logic        V;
  logic        halted;
  logic        illegal;

  modport master (
    input  instr, instr_valid, alu_z, alu_n, alu_v,
    output instr_ready, alu_op, shift, readnum, writenum, write, vsel, sximm8,
           loada, loadb, loadc, asel, Z, N, V, halted, illegal
  );

  modport slave (
    output instr, instr_valid, alu_z, alu_n, alu_v,
    input  instr_ready, alu_op, shift, readnum, writenum, write, vsel, sximm8,
           loada, loadb, loadc, asel, Z, N, V, halted, illegal
  );

endinterface

// File: rtl/cpu_ctrl_instr_dec.sv
// rtl/cpu_ctrl_instr_dec.sv - combinational IR field split, sign-extended imm8 and instruction class
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  op,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output iclass_t     iclass,
  output logic        illegal
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == MOV_IMM)      iclass = C_MOV_IMM;
        else if (op == MOV_REG) iclass = C_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          ALU_ADD: iclass = C_ADD;
          ALU_SUB: iclass = C_CMP;
          ALU_AND: iclass = C_AND;
          default: iclass = C_MVN;
        endcase
      end
      OPC_HALT: iclass = C_HALT;
      default:  iclass = C_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == C_ILLEGAL);

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle sequencer for the 16-bit datapath, owns IR and the Z/N/V status register
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.master bus
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        accept;

  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [1:0]  op;
  logic [1:0]  sh;
  logic [15:0] sximm8;
  iclass_t     iclass;
  logic        dec_illegal;

  instr_dec u_dec (
    .ir      (ir),
    .rn      (rn),
    .rd      (rd),
    .rm      (rm),
    .op      (op),
    .sh      (sh),
    .sximm8  (sximm8),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  assign accept = (state == S_WAIT) && bus.instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_WAIT;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) ir <= bus.instr;
      // CMP has no writeback; its only architectural effect is the flags.
      if (state == S_ALU && iclass == C_CMP) begin
        flag_z <= bus.alu_z;
        flag_n <= bus.alu_n;
        flag_v <= bus.alu_v;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.readnum     = '0;
    bus.writenum    = '0;
    bus.write       = 1'b0;
    bus.vsel        = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.loadc       = 1'b0;
    bus.asel        = 1'b0;
    bus.alu_op      = '0;
    bus.shift       = '0;
    bus.illegal     = 1'b0;
    bus.halted      = 1'b0;
    case (state)
      S_WAIT: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          bus.illegal = 1'b1;
          state_nxt   = S_WAIT;
        end else begin
          case (iclass)
            C_MOV_IMM:           state_nxt = S_WR_IMM;
            C_ADD, C_AND, C_CMP: state_nxt = S_GET_A;
            C_MVN, C_MOV_REG:    state_nxt = S_GET_B;
            C_HALT:              state_nxt = S_HALT;
            default:             state_nxt = S_WAIT;
          endcase
        end
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_nxt   = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_nxt   = S_ALU;
      end
      S_ALU: begin
        bus.shift = sh;
        case (iclass)
          C_MVN:   bus.alu_op = ALU_NOT;
          C_MOV_REG: begin
            // MOV reg passes shifted B through the adder with A forced to zero.
            bus.alu_op = ALU_ADD;
            bus.asel   = 1'b1;
          end
          default: bus.alu_op = op;
        endcase
        if (iclass == C_CMP) begin
          state_nxt = S_WAIT;
        end else begin
          bus.loadc = 1'b1;
          state_nxt = S_WR_REG;
        end
      end
      S_WR_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign bus.sximm8 = sximm8;
  assign bus.Z      = flag_z;
  assign bus.N      = flag_n;
  assign bus.V      = flag_v;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - table-driven and directed checks for cpu_ctrl
module tb_cpu_ctrl;

  logic clk = 1'b0;
  logic reset;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          lat;
    int          writes;
    logic [2:0]  wnum;
    logic        wvsel;
    int          ills;
    int          loadcs;
    int          alu_cyc;
    logic [1:0]  aop;
    logic        asel;
  } vec_t;

  vec_t vecs [10];

  int n_checks = 0;
  int n_pass   = 0;

  int         tr_lat;
  int         tr_writes;
  int         tr_ills;
  int         tr_loadcs;
  logic [2:0] tr_wnum;
  logic       tr_wvsel;
  logic [2:0] tr_readnum [1:8];
  logic       tr_loada   [1:8];
  logic       tr_loadb   [1:8];
  logic       tr_loadc   [1:8];
  logic       tr_asel    [1:8];
  logic [1:0] tr_aop     [1:8];
  logic [1:0] tr_shift   [1:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic accept_instr(input logic [15:0] ins);
    int waited = 0;
    @(negedge clk);
    while (!bus.instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_accept", {31'b0, bus.instr_ready}, 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input int alu_cyc,
                       input logic z, input logic n, input logic v);
    accept_instr(ins);
    tr_lat = 0; tr_writes = 0; tr_ills = 0; tr_loadcs = 0;
    tr_wnum = '0; tr_wvsel = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tr_readnum[i] = '0; tr_loada[i] = 1'b0; tr_loadb[i] = 1'b0; tr_loadc[i] = 1'b0;
      tr_asel[i] = 1'b0; tr_aop[i] = '0; tr_shift[i] = '0;
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.instr_ready) break;
      tr_lat = k;
      if (k <= 8) begin
        tr_readnum[k] = bus.readnum;
        tr_loada[k]   = bus.loada;
        tr_loadb[k]   = bus.loadb;
        tr_loadc[k]   = bus.loadc;
        tr_asel[k]    = bus.asel;
        tr_aop[k]     = bus.alu_op;
        tr_shift[k]   = bus.shift;
      end
      tr_writes += int'(bus.write);
      tr_ills   += int'(bus.illegal);
      tr_loadcs += int'(bus.loadc);
      if (bus.write) begin
        tr_wnum  = bus.writenum;
        tr_wvsel = bus.vsel;
      end
      if (k == alu_cyc) begin
        bus.alu_z = z; bus.alu_n = n; bus.alu_v = v;
      end else begin
        bus.alu_z = 1'b0; bus.alu_n = 1'b0; bus.alu_v = 1'b0;
      end
    end
    bus.alu_z = 1'b0; bus.alu_n = 1'b0; bus.alu_v = 1'b0;
  endtask

  initial begin
    int bad;
    //          instr     lat wr wnum vsel ill ldc alu aop   asel
    vecs[0] = '{16'hD0FF, 2, 1, 3'd0, 1'b1, 0, 0, 0, 2'b00, 1'b0};
    vecs[1] = '{16'hA0A1, 5, 1, 3'd5, 1'b0, 0, 1, 4, 2'b00, 1'b0};
    vecs[2] = '{16'hA901, 4, 0, 3'd0, 1'b0, 0, 0, 4, 2'b01, 1'b0};
    vecs[3] = '{16'hB0A1, 5, 1, 3'd5, 1'b0, 0, 1, 4, 2'b10, 1'b0};
    vecs[4] = '{16'hB8C2, 4, 1, 3'd6, 1'b0, 0, 1, 3, 2'b11, 1'b0};
    vecs[5] = '{16'hC0E9, 4, 1, 3'd7, 1'b0, 0, 1, 3, 2'b00, 1'b1};
    vecs[6] = '{16'h0000, 1, 0, 3'd0, 1'b0, 1, 0, 0, 2'b00, 1'b0};
    vecs[7] = '{16'hC800, 1, 0, 3'd0, 1'b0, 1, 0, 0, 2'b00, 1'b0};
    vecs[8] = '{16'hD800, 1, 0, 3'd0, 1'b0, 1, 0, 0, 2'b00, 1'b0};
    vecs[9] = '{16'h2000, 1, 0, 3'd0, 1'b0, 1, 0, 0, 2'b00, 1'b0};

    bus.instr = '0; bus.instr_valid = 1'b0;
    bus.alu_z = 1'b0; bus.alu_n = 1'b0; bus.alu_v = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_write",  {31'b0, bus.write},  32'd0);
    chk("rst_loada",  {31'b0, bus.loada},  32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("rst_znv",    {29'b0, bus.Z, bus.N, bus.V}, 32'd0);
    chk("rst_sximm8", {16'b0, bus.sximm8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'b0, bus.instr_ready}, 32'd1);

    issue(16'hD0FF, 0, 1'b0, 1'b0, 1'b0);
    chk("movi_sximm8", {16'b0, bus.sximm8}, 32'h0000FFFF);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].instr, vecs[i].alu_cyc, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_lat", i),    tr_lat,    vecs[i].lat);
      chk($sformatf("v%0d_writes", i), tr_writes, vecs[i].writes);
      chk($sformatf("v%0d_wnum", i),   {29'b0, tr_wnum},  {29'b0, vecs[i].wnum});
      chk($sformatf("v%0d_vsel", i),   {31'b0, tr_wvsel}, {31'b0, vecs[i].wvsel});
      chk($sformatf("v%0d_ill", i),    tr_ills,   vecs[i].ills);
      chk($sformatf("v%0d_loadc", i),  tr_loadcs, vecs[i].loadcs);
      if (vecs[i].alu_cyc != 0) begin
        chk($sformatf("v%0d_aluop", i), {30'b0, tr_aop[vecs[i].alu_cyc]},  {30'b0, vecs[i].aop});
        chk($sformatf("v%0d_asel", i),  {31'b0, tr_asel[vecs[i].alu_cyc]}, {31'b0, vecs[i].asel});
      end
    end

    issue(16'hA0A1, 4, 1'b0, 1'b0, 1'b0);
    chk("add_rd_a",  {29'b0, tr_readnum[2]}, 32'd0);
    chk("add_loada", {31'b0, tr_loada[2]},   32'd1);
    chk("add_rd_b",  {29'b0, tr_readnum[3]}, 32'd1);
    chk("add_loadb", {31'b0, tr_loadb[3]},   32'd1);
    chk("add_loadc", {31'b0, tr_loadc[4]},   32'd1);

    issue(16'hA901, 4, 1'b1, 1'b0, 1'b1);
    chk("cmp_flags",  {29'b0, bus.Z, bus.N, bus.V}, 32'b101);
    chk("cmp_writes", tr_writes, 0);
    issue(16'hA0A1, 4, 1'b0, 1'b1, 1'b0);
    chk("add_keeps_flags", {29'b0, bus.Z, bus.N, bus.V}, 32'b101);

    issue(16'hC0E9, 3, 1'b0, 1'b0, 1'b0);
    chk("movr_rd_b",  {29'b0, tr_readnum[2]}, 32'd1);
    chk("movr_shift", {30'b0, tr_shift[3]},   32'b01);
    chk("movr_asel",  {31'b0, tr_asel[3]},    32'd1);
    issue(16'h0000, 0, 1'b0, 1'b0, 1'b0);
    chk("ill_pulse", tr_ills, 1);
    chk("ill_lat",   tr_lat,  1);

    accept_instr(16'hE000);
    bus.instr = 16'hA0A1;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.halted || bus.instr_ready || bus.write) bad++;
    end
    chk("halt_hold", bad, 0);
    bus.instr_valid = 1'b0;

    #2 reset = 1'b1;
    #1;
    chk("halt_reset", {31'b0, bus.halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    accept_instr(16'hA0A1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_getb", {31'b0, bus.loadb}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_strobes", {28'b0, bus.loada, bus.loadb, bus.loadc, bus.write}, 32'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      if (bus.write || bus.loadc) bad++;
    end
    chk("abort_no_write", bad, 0);
    chk("abort_ready", {31'b0, bus.instr_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
